// File: rtl/cmd_frame_decoder.sv
// cmd_frame_decoder: assembles 6-byte SYNC/CMD/ADDR/DHI/DLO/CSUM frames from a
// byte-strobe stream, checks the 8-bit sum and issues write/read register strobes.
module cmd_frame_decoder #(
    parameter logic [15:0] TIMEOUT = 16'd2000,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter logic [7:0]  CMD_WR  = 8'h57,
    parameter logic [7:0]  CMD_RD  = 8'h52
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        newrxstrobe,
    input  logic [7:0]  rxbyte,
    input  logic        err_clr,
    output logic        wr_stb,
    output logic        rd_stb,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DHI, DLO, CSUM} state_t;

    state_t      state;
    logic [7:0]  op, addr, dhi, dlo, sum, sum_next;
    logic [15:0] cnt;
    logic        err;

    // A byte arriving in the expiry cycle takes priority over the timeout.
    always_comb begin
        sum_next = sum + rxbyte;
        err = (newrxstrobe && state == CMD && rxbyte != CMD_WR && rxbyte != CMD_RD)
           || (newrxstrobe && state == CSUM && sum_next != 8'd0)
           || (!newrxstrobe && state != IDLE && cnt == TIMEOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= 8'd0;
            addr      <= 8'd0;
            dhi       <= 8'd0;
            dlo       <= 8'd0;
            sum       <= 8'd0;
            cnt       <= 16'd0;
            wr_stb    <= 1'b0;
            rd_stb    <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            cmd_addr  <= 8'd0;
            cmd_data  <= 16'd0;
            err_count <= 8'd0;
        end else begin
            wr_stb    <= 1'b0;
            rd_stb    <= 1'b0;
            frame_err <= err;
            cnt       <= (state == IDLE || newrxstrobe || err) ? 16'd0 : cnt + 16'd1;
            if (err_clr)
                err_count <= {7'd0, err};
            else if (err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            if (err) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (newrxstrobe) begin
                case (state)
                    IDLE: if (rxbyte == SYNC) begin
                        state <= CMD;
                        busy  <= 1'b1;
                    end
                    CMD: begin
                        op    <= rxbyte;
                        sum   <= rxbyte;
                        state <= ADDR;
                    end
                    ADDR: begin
                        addr  <= rxbyte;
                        sum   <= sum_next;
                        state <= DHI;
                    end
                    DHI: begin
                        dhi   <= rxbyte;
                        sum   <= sum_next;
                        state <= DLO;
                    end
                    DLO: begin
                        dlo   <= rxbyte;
                        sum   <= sum_next;
                        state <= CSUM;
                    end
                    CSUM: begin
                        cmd_addr <= addr;
                        cmd_data <= {dhi, dlo};
                        wr_stb   <= (op == CMD_WR);
                        rd_stb   <= (op == CMD_RD);
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cmd_frame_decoder.sv
// tb_cmd_frame_decoder: table vectors, timing corner sequences and a random
// byte stream checked against a frame-level parser model.
module tb_cmd_frame_decoder;
    localparam logic [15:0] TIMEOUT = 16'd2000;

    logic        clk = 1'b0;
    logic        rst, newrxstrobe, err_clr;
    logic [7:0]  rxbyte;
    logic        wr_stb, rd_stb, frame_err, busy;
    logic [7:0]  cmd_addr, err_count;
    logic [15:0] cmd_data;

    int total = 0, bad = 0;
    int n_wr = 0, n_rd = 0, n_err = 0, excl_bad = 0;

    typedef struct {
        int          n;
        logic [47:0] b;
        logic        wr, rd, er;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [7:0]  ec;
    } vec_t;

    vec_t       tbl[9];
    logic [7:0] q[$];

    always #5 clk = ~clk;

    cmd_frame_decoder #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .newrxstrobe(newrxstrobe), .rxbyte(rxbyte),
        .err_clr(err_clr), .wr_stb(wr_stb), .rd_stb(rd_stb), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .frame_err(frame_err), .err_count(err_count), .busy(busy)
    );

    always @(negedge clk) if (!rst) begin
        if (wr_stb) n_wr++;
        if (rd_stb) n_rd++;
        if (frame_err) n_err++;
        if (int'(wr_stb) + int'(rd_stb) + int'(frame_err) > 1) excl_bad++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        newrxstrobe = 1'b1;
        rxbyte      = b;
        @(negedge clk);
        newrxstrobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [47:0] b, input int n);
        for (int j = 0; j < n; j++) begin
            if (j > 0) idle(9);
            send_byte(b[47-8*j -: 8]);
        end
    endtask

    initial begin
        int         w0, r0, e0;
        int         m_wr, m_rd, m_err, i;
        logic [7:0] m_addr, c, s, a, h, l, k;
        logic [15:0] m_data;

        tbl[0] = '{6, 48'hA55710123453, 1'b1, 1'b0, 1'b0, 8'h10, 16'h1234, 8'd0};
        tbl[1] = '{6, 48'hA5523C000072, 1'b0, 1'b1, 1'b0, 8'h3C, 16'h0000, 8'd0};
        tbl[2] = '{6, 48'hA55710123454, 1'b0, 1'b0, 1'b1, 8'h3C, 16'h0000, 8'd1};
        tbl[3] = '{6, 48'hA55720ABCD11, 1'b1, 1'b0, 1'b0, 8'h20, 16'hABCD, 8'd1};
        tbl[4] = '{2, 48'hA54100000000, 1'b0, 1'b0, 1'b1, 8'h20, 16'hABCD, 8'd2};
        tbl[5] = '{2, 48'hA5A500000000, 1'b0, 1'b0, 1'b1, 8'h20, 16'hABCD, 8'd3};
        tbl[6] = '{3, 48'h00FF12000000, 1'b0, 1'b0, 1'b0, 8'h20, 16'hABCD, 8'd3};
        tbl[7] = '{6, 48'hA552FFFFFFB1, 1'b0, 1'b1, 1'b0, 8'hFF, 16'hFFFF, 8'd3};
        tbl[8] = '{6, 48'hA557000000A9, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 8'd3};

        rst = 1'b1; newrxstrobe = 1'b0; rxbyte = 8'd0; err_clr = 1'b0;
        idle(3);
        chk("reset_outputs", {wr_stb, rd_stb, frame_err, busy, cmd_addr, cmd_data, err_count},
            32'd0);
        rst = 1'b0;
        idle(2);

        for (int r = 0; r < 9; r++) begin
            w0 = n_wr; r0 = n_rd; e0 = n_err;
            send_bytes(tbl[r].b, tbl[r].n);
            chk($sformatf("row%0d_strobes", r), {wr_stb, rd_stb, frame_err, busy},
                {tbl[r].wr, tbl[r].rd, tbl[r].er, 1'b0});
            chk($sformatf("row%0d_addr", r), cmd_addr, tbl[r].addr);
            chk($sformatf("row%0d_data", r), cmd_data, tbl[r].data);
            chk($sformatf("row%0d_errcnt", r), err_count, tbl[r].ec);
            idle(1);
            chk($sformatf("row%0d_pulse_counts", r), {n_wr - w0, n_rd - r0, n_err - e0},
                {32'(tbl[r].wr), 32'(tbl[r].rd), 32'(tbl[r].er)});
            idle(8);
        end

        // Stall after A5 57: error one clock after the counter reaches TIMEOUT.
        send_byte(8'hA5); idle(9); send_byte(8'h57);
        idle(TIMEOUT);
        chk("tmo_before_expiry", {frame_err, busy}, 2'b01);
        idle(1);
        chk("tmo_err_pulse", {frame_err, busy, err_count}, {2'b10, 8'd4});
        idle(1);
        chk("tmo_err_single", frame_err, 1'b0);
        idle(9);
        send_bytes(48'hA55720ABCD11, 6);
        chk("tmo_next_frame", {wr_stb, cmd_addr, cmd_data}, {1'b1, 8'h20, 16'hABCD});
        idle(10);

        // Bytes landing exactly in the expiry cycle are accepted.
        e0 = n_err; w0 = n_wr;
        send_byte(8'hA5); idle(9); send_byte(8'h57);
        idle(TIMEOUT); send_byte(8'h10);
        idle(TIMEOUT); send_byte(8'h12);
        idle(9); send_byte(8'h34); idle(9); send_byte(8'h53);
        chk("edge_tmo_wr", {wr_stb, cmd_addr, cmd_data}, {1'b1, 8'h10, 16'h1234});
        idle(1);
        chk("edge_tmo_counts", {n_err - e0, n_wr - w0}, {32'd0, 32'd1});
        idle(8);

        for (int j = 0; j < 260; j++) begin
            send_byte(8'hA5); idle(9); send_byte(8'h41); idle(9);
        end
        chk("err_saturate", err_count, 8'd255);
        send_byte(8'hA5); idle(9);
        err_clr = 1'b1;
        send_byte(8'h41);
        err_clr = 1'b0;
        chk("clr_with_err", {frame_err, err_count}, {1'b1, 8'd1});
        idle(3);
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        chk("clr_alone", err_count, 8'd0);
        idle(9);

        send_byte(8'hA5); idle(9); send_byte(8'h57); idle(9); send_byte(8'h10); idle(4);
        rst = 1'b1;
        #1;
        chk("async_reset", {wr_stb, rd_stb, frame_err, busy, cmd_addr, cmd_data, err_count},
            32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        e0 = n_err;
        send_bytes(48'hA5523C000072, 6);
        chk("post_reset_rd", {rd_stb, wr_stb, cmd_addr, cmd_data}, {2'b10, 8'h3C, 16'h0000});
        idle(1);
        chk("post_reset_no_err", {n_err - e0, 24'd0, err_count}, 32'd0);
        idle(8);

        // Random stream: valid frames, bad sums, bad commands and garbage.
        for (int it = 0; it < 30; it++) begin
            a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
            c = ($urandom_range(0, 1) == 0) ? 8'h57 : 8'h52;
            s = 8'(0) - (c + a + h + l);
            case ($urandom_range(0, 4))
                0, 1: q.push_back(8'hA5);
                2: begin q.push_back(8'hA5); s = s + 8'($urandom_range(1, 255)); end
                3: begin
                    do k = 8'($urandom); while (k == 8'h57 || k == 8'h52);
                    q.push_back(8'hA5); q.push_back(k);
                    c = 8'h00;
                end
                default: begin
                    for (int g = $urandom_range(1, 3); g > 0; g--) q.push_back(8'($urandom));
                    c = 8'h00;
                end
            endcase
            if (c != 8'h00) begin
                q.push_back(c); q.push_back(a); q.push_back(h); q.push_back(l); q.push_back(s);
            end
        end
        w0 = n_wr; r0 = n_rd; e0 = n_err;
        foreach (q[j]) begin
            send_byte(q[j]);
            idle($urandom_range(9, 14));
        end
        idle(int'(TIMEOUT) + 20);

        m_wr = 0; m_rd = 0; m_err = 0; m_addr = 8'h3C; m_data = 16'h0000; i = 0;
        while (i < q.size()) begin
            if (q[i] != 8'hA5) begin i++; continue; end
            if (i + 1 >= q.size()) begin m_err++; break; end
            if (q[i+1] != 8'h57 && q[i+1] != 8'h52) begin m_err++; i += 2; continue; end
            if (i + 5 >= q.size()) begin m_err++; break; end
            s = q[i+1] + q[i+2] + q[i+3] + q[i+4] + q[i+5];
            if (s != 8'd0) m_err++;
            else begin
                if (q[i+1] == 8'h57) m_wr++; else m_rd++;
                m_addr = q[i+2];
                m_data = {q[i+3], q[i+4]};
            end
            i += 6;
        end
        chk("rand_wr_count", n_wr - w0, m_wr);
        chk("rand_rd_count", n_rd - r0, m_rd);
        chk("rand_err_count", n_err - e0, m_err);
        chk("rand_err_reg", err_count, (m_err > 255) ? 255 : m_err);
        chk("rand_addr", cmd_addr, m_addr);
        chk("rand_data", cmd_data, m_data);
        chk("rand_busy_idle", busy, 1'b0);
        chk("strobe_exclusive", excl_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
